// File: rtl/cfg_master.sv
// Configuration-bus initiator: decodes HEADER/ADDR/DATA/SUM frames from the
// UART byte stream and issues one handshaked write per valid frame.
module cfg_master #(
    parameter int          WIDTH_CONFIG_ADDR = 4,
    parameter int          WIDTH_CONFIG_DATA = 8,
    parameter logic [7:0]  HEADER            = 8'hA5,
    parameter int          TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    output logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_valid,
    input  logic                         c_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic                         rx_drop
);

    localparam logic [1:0]  CODE_OK      = 2'd0;
    localparam logic [1:0]  CODE_SUM     = 2'd1;
    localparam logic [1:0]  CODE_ADDR    = 2'd2;
    localparam logic [1:0]  CODE_TIMEOUT = 2'd3;
    localparam logic [15:0] TO_LAST      = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DATA,
        S_SUM,
        S_ISSUE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  addr_byte;
    logic [7:0]  data_byte;
    logic [15:0] to_cnt;

    logic        cap_addr, cap_data, load_bus, cnt_clr, cnt_inc;
    logic        done_nxt, err_nxt;
    logic [1:0]  err_code_nxt;

    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] d);
        return a ^ d ^ 8'h5A;
    endfunction

    // Address bits above the configured bus width must be clear.
    function automatic logic addr_out_of_range(input logic [7:0] a);
        if (WIDTH_CONFIG_ADDR >= 8)
            return 1'b0;
        return (a >> WIDTH_CONFIG_ADDR) != 8'd0;
    endfunction

    always_comb begin
        state_nxt    = state;
        cap_addr     = 1'b0;
        cap_data     = 1'b0;
        load_bus     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        err_code_nxt = err_code;

        case (state)
            S_HDR: begin
                if (rx_valid && rx_data == HEADER)
                    state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (rx_valid) begin
                    cap_addr  = 1'b1;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    cap_data  = 1'b1;
                    state_nxt = S_SUM;
                end
            end
            S_SUM: begin
                if (rx_valid) begin
                    state_nxt = S_HDR;
                    if (rx_data != frame_sum(addr_byte, data_byte)) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = CODE_SUM;
                    end else if (addr_out_of_range(addr_byte)) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = CODE_ADDR;
                    end else begin
                        load_bus  = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A handshake on the final allowed cycle still counts as success.
                if (c_ready) begin
                    done_nxt     = 1'b1;
                    err_code_nxt = CODE_OK;
                    state_nxt    = S_HDR;
                end else if (to_cnt == TO_LAST) begin
                    err_nxt      = 1'b1;
                    err_code_nxt = CODE_TIMEOUT;
                    state_nxt    = S_HDR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HDR;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= CODE_OK;
            to_cnt   <= 16'd0;
            c_addr   <= '0;
            c_data   <= '0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            err_code <= err_code_nxt;
            if (cnt_clr)
                to_cnt <= 16'd0;
            else if (cnt_inc)
                to_cnt <= to_cnt + 16'd1;
            if (load_bus) begin
                c_addr <= addr_byte[WIDTH_CONFIG_ADDR-1:0];
                c_data <= data_byte[WIDTH_CONFIG_DATA-1:0];
            end
        end
    end

    // Frame payload capture; only meaningful once the checksum byte arrives.
    always_ff @(posedge clk) begin
        if (cap_addr)
            addr_byte <= rx_data;
        if (cap_data)
            data_byte <= rx_data;
    end

    assign c_valid = (state == S_ISSUE);
    assign busy    = (state != S_HDR);
    assign rx_drop = (state == S_ISSUE) && rx_valid;

endmodule
